// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller.
//
// Serves load/store requests from the MEM stage and word fetches from the IF
// stage over an 8-bit synchronous RAM port. Each request is split into 1, 2 or
// 4 sequential byte accesses, little-endian. Loads are assembled and sign- or
// zero-extended. One transaction at a time; MEM has priority over IF.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   mem_req_i..       MEM-stage request (we, addr, wdata, size, signed)
//   mem_done_o        one-cycle MEM completion pulse
//   mem_rdata_o       MEM load result, held until the next MEM load completes
//   if_req_i, if_addr_i   fetch request (unsigned word read)
//   if_done_o, if_inst_o  fetch completion pulse and held fetched word
//   ram_a_o, ram_dout_o, ram_wr_o   registered RAM address / write byte / enable
//   ram_din_i         RAM read byte, valid the cycle after the address is sampled
module mem_ctrl #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [1:0]        mem_size_i,
    input  logic              mem_signed_i,
    output logic              mem_done_o,
    output logic [31:0]       mem_rdata_o,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic              if_done_o,
    output logic [31:0]       if_inst_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [31:0]       r_wdata, w_wdata_nxt;
    logic [1:0]        r_size, w_size_nxt;
    logic              r_signed, w_signed_nxt;
    logic              r_src_if, w_src_if_nxt;
    logic [31:0]       r_data, w_data_nxt;
    logic [ADDR_W-1:0] r_ram_a, w_ram_a_nxt;
    logic [7:0]        r_ram_dout, w_ram_dout_nxt;
    logic              r_ram_wr, w_ram_wr_nxt;
    logic [31:0]       r_mem_rdata, w_mem_rdata_nxt;
    logic [31:0]       r_if_inst, w_if_inst_nxt;

    logic [2:0]        w_n;
    logic [2:0]        w_cap_idx;
    logic [31:0]       w_rd_full;
    logic [31:0]       w_ext;

    // Address bits above ADDR_W are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{mem_addr_i[31:ADDR_W], if_addr_i[31:ADDR_W]};

    // Byte count, capture index and the final assembled/extended load value.
    always_comb begin
        w_n = 3'd4;
        case (r_size)
            2'b00:   w_n = 3'd1;
            2'b01:   w_n = 3'd2;
            default: w_n = 3'd4;
        endcase

        // In READ, the byte captured at this edge is the one issued two edges ago.
        w_cap_idx = r_cnt - 3'd2;

        // Merge the last byte straight from the RAM so the result is ready at
        // the same edge that captures it.
        w_rd_full = r_data;
        case (r_size)
            2'b00:   w_rd_full[7:0]   = ram_din_i;
            2'b01:   w_rd_full[15:8]  = ram_din_i;
            default: w_rd_full[31:24] = ram_din_i;
        endcase

        w_ext = w_rd_full;
        case (r_size)
            2'b00:   w_ext = r_signed ? {{24{w_rd_full[7]}}, w_rd_full[7:0]}
                                      : {24'b0, w_rd_full[7:0]};
            2'b01:   w_ext = r_signed ? {{16{w_rd_full[15]}}, w_rd_full[15:0]}
                                      : {16'b0, w_rd_full[15:0]};
            default: w_ext = w_rd_full;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_size_nxt      = r_size;
        w_signed_nxt    = r_signed;
        w_src_if_nxt    = r_src_if;
        w_data_nxt      = r_data;
        w_ram_a_nxt     = r_ram_a;
        w_ram_dout_nxt  = r_ram_dout;
        w_ram_wr_nxt    = 1'b0;
        w_mem_rdata_nxt = r_mem_rdata;
        w_if_inst_nxt   = r_if_inst;

        unique case (r_state)
            StIdle: begin
                if (mem_req_i) begin
                    w_addr_nxt   = mem_addr_i[ADDR_W-1:0];
                    w_wdata_nxt  = mem_wdata_i;
                    w_size_nxt   = mem_size_i;
                    w_signed_nxt = mem_signed_i;
                    w_src_if_nxt = 1'b0;
                    w_cnt_nxt    = 3'd1;
                    w_data_nxt   = '0;
                    w_ram_a_nxt  = mem_addr_i[ADDR_W-1:0];
                    if (mem_we_i) begin
                        // Byte 0 goes out on the accepting edge.
                        w_ram_dout_nxt = mem_wdata_i[7:0];
                        w_ram_wr_nxt   = 1'b1;
                        w_state_nxt    = StWrite;
                    end else begin
                        w_state_nxt = StRead;
                    end
                end else if (if_req_i) begin
                    w_addr_nxt   = if_addr_i[ADDR_W-1:0];
                    w_size_nxt   = 2'b10;
                    w_signed_nxt = 1'b0;
                    w_src_if_nxt = 1'b1;
                    w_cnt_nxt    = 3'd1;
                    w_data_nxt   = '0;
                    w_ram_a_nxt  = if_addr_i[ADDR_W-1:0];
                    w_state_nxt  = StRead;
                end
            end

            StWrite: begin
                if (r_cnt == w_n) begin
                    w_state_nxt = StDone;
                end else begin
                    w_ram_a_nxt    = r_addr + ADDR_W'(r_cnt);
                    w_ram_dout_nxt = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                    w_ram_wr_nxt   = 1'b1;
                    w_cnt_nxt      = r_cnt + 3'd1;
                end
            end

            StRead: begin
                // r_cnt doubles as the edge index since acceptance.
                if (r_cnt < w_n) begin
                    w_ram_a_nxt = r_addr + ADDR_W'(r_cnt);
                end
                if (r_cnt >= 3'd2) begin
                    w_data_nxt[{w_cap_idx[1:0], 3'b000} +: 8] = ram_din_i;
                end
                if (r_cnt == w_n + 3'd1) begin
                    if (r_src_if) begin
                        w_if_inst_nxt = w_ext;
                    end else begin
                        w_mem_rdata_nxt = w_ext;
                    end
                    w_state_nxt = StDone;
                end else begin
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end

            StDone: begin
                w_state_nxt = StIdle;
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_signed    <= 1'b0;
            r_src_if    <= 1'b0;
            r_data      <= '0;
            r_ram_a     <= '0;
            r_ram_dout  <= '0;
            r_ram_wr    <= 1'b0;
            r_mem_rdata <= '0;
            r_if_inst   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_size      <= w_size_nxt;
            r_signed    <= w_signed_nxt;
            r_src_if    <= w_src_if_nxt;
            r_data      <= w_data_nxt;
            r_ram_a     <= w_ram_a_nxt;
            r_ram_dout  <= w_ram_dout_nxt;
            r_ram_wr    <= w_ram_wr_nxt;
            r_mem_rdata <= w_mem_rdata_nxt;
            r_if_inst   <= w_if_inst_nxt;
        end
    end

    assign mem_done_o  = (r_state == StDone) && !r_src_if;
    assign if_done_o   = (r_state == StDone) && r_src_if;
    assign mem_rdata_o = r_mem_rdata;
    assign if_inst_o   = r_if_inst;
    assign ram_a_o     = r_ram_a;
    assign ram_dout_o  = r_ram_dout;
    assign ram_wr_o    = r_ram_wr;

endmodule
